// File: rtl/wish_pkg.sv
// ---------------------------------------------------------------------------
// wish_pkg
// Shared definitions for the wish_block_master block-transfer initiator:
// default bus/length widths, the controller state encoding and a helper that
// sizes the per-word timeout counter.
// ---------------------------------------------------------------------------
package wish_pkg;

  localparam int WISH_ADDR_W    = 32;
  localparam int WISH_DATA_W    = 16;
  localparam int WISH_LEN_W     = 16;
  localparam int WISH_ADDR_STEP = 1;
  localparam int WISH_TIMEOUT   = 1024;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_REQ   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_PUSH  = 3'd4,
    ST_NEXT  = 3'd5,
    ST_DONE  = 3'd6
  } wish_state_e;

  // Plain constants with the same encoding, for legacy-style state registers
  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_FETCH = ST_FETCH;
  localparam logic [2:0] S_REQ   = ST_REQ;
  localparam logic [2:0] S_WAIT  = ST_WAIT;
  localparam logic [2:0] S_PUSH  = ST_PUSH;
  localparam logic [2:0] S_NEXT  = ST_NEXT;
  localparam logic [2:0] S_DONE  = ST_DONE;

  // Counter must be able to hold the value TIMEOUT itself
  function automatic int tmo_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/wish_block_master_if.sv
// ---------------------------------------------------------------------------
// mem_wif_t
// Single-word memory bus between an initiator (dev) and the SDRAM responder.
//   dev drives   : clk_i, rst_i, stb_i, we_i, sel_i, addr_i, dat_i
//   slave drives : cyc_o (accept/busy), stb_o, dat_o (read data)
// A word completes when cyc_o falls; read data is valid on that edge.
// ---------------------------------------------------------------------------
interface mem_wif_t
  import wish_pkg::*;
#(
  parameter int ADDR_W = WISH_ADDR_W,
  parameter int DATA_W = WISH_DATA_W
);
  logic              clk_i;
  logic              rst_i;
  logic              stb_i;
  logic              we_i;
  logic              sel_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] dat_i;
  logic              cyc_o;
  logic              stb_o;
  logic [DATA_W-1:0] dat_o;

  modport dev (
    output clk_i, rst_i, stb_i, we_i, sel_i, addr_i, dat_i,
    input  cyc_o, stb_o, dat_o
  );

  modport slave (
    input  clk_i, rst_i, stb_i, we_i, sel_i, addr_i, dat_i,
    output cyc_o, stb_o, dat_o
  );
endinterface

// File: rtl/wish_block_master.sv
// ---------------------------------------------------------------------------
// wish_block_master
// Turns one block command (base address, word count, direction) into a run
// of single-word transactions on mem_wif_t. Write words come from the
// in_* stream, read words leave on the out_* stream.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset (also to bus)
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_write/addr/len    direction, base address, word count
//   in_data/valid/ready   write stream, in_ready is a one-cycle accept pulse
//   out_data/valid/ready  read stream, out_valid held until out_ready
//   done, err, xfer_cnt   completion pulse, timeout flag, words completed
//   wif                   bus, dev side
// ---------------------------------------------------------------------------
module wish_block_master
  import wish_pkg::*;
#(
  parameter int ADDR_W    = WISH_ADDR_W,
  parameter int DATA_W    = WISH_DATA_W,
  parameter int LEN_W     = WISH_LEN_W,
  parameter int ADDR_STEP = WISH_ADDR_STEP,
  parameter int TIMEOUT   = WISH_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              done,
  output logic              err,
  output logic [LEN_W-1:0]  xfer_cnt,
  mem_wif_t.dev             wif
);

  localparam int TMO_W = tmo_width(TIMEOUT);

  logic [2:0]        r_state;
  logic              r_cmd_ready;
  logic              r_stb;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_dat;
  logic [LEN_W-1:0]  r_remaining;
  logic [LEN_W-1:0]  r_xfer_cnt;
  logic [TMO_W-1:0]  r_tmo;
  logic              r_in_ready;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_done;
  logic              r_err;
  logic              w_tmo_hit;

  // ">=" rather than "==": the counter may already sit at TIMEOUT when
  // cyc_o and the limit coincide in REQ, and WAIT must still abort.
  assign w_tmo_hit = (r_tmo >= TMO_W'(TIMEOUT - 1));

  assign wif.clk_i  = clk_i;
  assign wif.rst_i  = rst_i;
  assign wif.stb_i  = r_stb;
  assign wif.sel_i  = r_stb;
  assign wif.we_i   = r_we;
  assign wif.addr_i = r_addr;
  assign wif.dat_i  = r_dat;

  assign cmd_ready = r_cmd_ready;
  assign in_ready  = r_in_ready;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign done      = r_done;
  assign err       = r_err;
  assign xfer_cnt  = r_xfer_cnt;

  // Transfer controller: state, bus drive, stream handshakes, counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b1;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_dat       <= '0;
      r_remaining <= '0;
      r_xfer_cnt  <= '0;
      r_tmo       <= '0;
      r_in_ready  <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_in_ready <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_we        <= cmd_write;
            r_addr      <= cmd_addr;
            r_remaining <= cmd_len;
            r_err       <= 1'b0;
            r_xfer_cnt  <= '0;
            r_cmd_ready <= 1'b0;
            if (cmd_len == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else if (cmd_write) begin
              r_state <= S_FETCH;
            end else begin
              r_state <= S_REQ;
              r_stb   <= 1'b1;
              r_tmo   <= '0;
            end
          end
        end
        S_FETCH: begin
          if (in_valid) begin
            r_dat      <= in_data;
            r_in_ready <= 1'b1;
            r_state    <= S_REQ;
            r_stb      <= 1'b1;
            r_tmo      <= '0;
          end
        end
        S_REQ: begin
          if (wif.cyc_o) begin
            r_stb   <= 1'b0;
            r_state <= S_WAIT;
            r_tmo   <= r_tmo + TMO_W'(1);
          end else if (w_tmo_hit) begin
            r_stb   <= 1'b0;
            r_err   <= 1'b1;
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        S_WAIT: begin
          // cyc_o was 1 when WAIT was entered, so a low cyc_o here is the fall
          if (!wif.cyc_o) begin
            if (r_we) begin
              r_state <= S_NEXT;
            end else begin
              r_out_data  <= wif.dat_o;
              r_out_valid <= 1'b1;
              r_state     <= S_PUSH;
            end
          end else if (w_tmo_hit) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        S_PUSH: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_NEXT;
          end
        end
        S_NEXT: begin
          r_addr      <= r_addr + ADDR_W'(ADDR_STEP);
          r_xfer_cnt  <= r_xfer_cnt + LEN_W'(1);
          r_remaining <= r_remaining - LEN_W'(1);
          if (r_remaining == LEN_W'(1)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else if (r_we) begin
            r_state <= S_FETCH;
          end else begin
            r_state <= S_REQ;
            r_stb   <= 1'b1;
            r_tmo   <= '0;
          end
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
        end
        default: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
          r_stb       <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wish_block_master.sv
// ---------------------------------------------------------------------------
// tb_wish_block_master
// Self-checking bench: a small bus responder (accept one cycle after stb_i,
// busy three cycles, read data = addr[15:0] ^ 16'hA5A5), a write-stream
// producer with programmable gaps and a read-stream collector. Each task
// drives one scenario and compares against values derived from the
// command itself.
// ---------------------------------------------------------------------------
module tb_wish_block_master;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_len;
  logic [15:0] in_data = 16'h0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid, out_ready;
  logic        done, err;
  logic [15:0] xfer_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_wif_t #(.ADDR_W(32), .DATA_W(16)) wif ();

  wish_block_master #(
    .ADDR_W(32), .DATA_W(16), .LEN_W(16), .ADDR_STEP(1), .TIMEOUT(TMO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .done(done), .err(err), .xfer_cnt(xfer_cnt),
    .wif(wif)
  );

  // ---------------- responder ----------------
  typedef struct packed { logic we; logic [31:0] addr; logic [15:0] dat; } txn_t;
  txn_t txn_q[$];
  logic resp_on;
  int   rs = 0;
  int   hold = 0;

  always @(posedge clk) begin
    if (rst) begin
      rs <= 0; hold <= 0;
      wif.cyc_o <= 1'b0; wif.stb_o <= 1'b0; wif.dat_o <= 16'h0;
    end else begin
      case (rs)
        0: if (resp_on && wif.stb_i && !wif.cyc_o) begin
             txn_q.push_back({wif.we_i, wif.addr_i, wif.dat_i});
             wif.dat_o <= wif.addr_i[15:0] ^ 16'hA5A5;
             rs <= 1;
           end
        1: begin wif.cyc_o <= 1'b1; wif.stb_o <= 1'b1; hold <= 0; rs <= 2; end
        2: if (hold == 2) begin wif.cyc_o <= 1'b0; wif.stb_o <= 1'b0; rs <= 0; end
           else hold <= hold + 1;
        default: rs <= 0;
      endcase
    end
  end

  // ---------------- monitors ----------------
  int done_cnt = 0, stb_cycles = 0, stb_viol = 0, sel_viol = 0;
  logic prev_stb = 1'b0, prev_ovl = 1'b0;
  logic [15:0] out_q[$];

  always @(negedge clk) begin
    if (rst) begin
      prev_stb <= 1'b0; prev_ovl <= 1'b0;
    end else begin
      if (done === 1'b1) done_cnt <= done_cnt + 1;
      if (out_valid === 1'b1 && out_ready === 1'b1) out_q.push_back(out_data);
      if (wif.stb_i === 1'b1) stb_cycles <= stb_cycles + 1;
      if (wif.sel_i !== wif.stb_i) sel_viol <= sel_viol + 1;
      // new strobe under a busy responder, or overlap lasting past one cycle
      if (wif.stb_i && wif.cyc_o && (!prev_stb || prev_ovl)) stb_viol <= stb_viol + 1;
      prev_stb <= wif.stb_i;
      prev_ovl <= wif.stb_i && wif.cyc_o;
    end
  end

  // ---------------- write-stream producer ----------------
  logic [15:0] prod_q[$];
  int prod_gap_max = 0;
  int gap = 0;

  always @(negedge clk) begin
    if (in_valid && in_ready === 1'b1) begin
      if (prod_q.size() > 0) void'(prod_q.pop_front());
      in_valid = 1'b0;
      gap = prod_gap_max;
    end else if (!in_valid && prod_q.size() > 0) begin
      if (gap > 0) gap = gap - 1;
      else begin in_data = prod_q[0]; in_valid = 1'b1; end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue_cmd(input logic wr, input logic [31:0] a, input logic [15:0] n);
    int k = 0;
    while (cmd_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = n;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output logic seen, output int cycles,
                           output logic e, output logic [15:0] x);
    seen = 1'b0; cycles = 0; e = 1'bx; x = 16'hxxxx;
    while (!seen && cycles < budget) begin
      @(negedge clk); cycles++;
      if (done === 1'b1) begin seen = 1'b1; e = err; x = xfer_cnt; end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; repeat (3) @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
    n_checks++; if ({wif.stb_i, wif.we_i, wif.sel_i, in_ready, out_valid, done, err} !== 7'b0) begin
      n_fail++; $display("FAIL reset_flags got=%b want=0000000", {wif.stb_i, wif.we_i, wif.sel_i, in_ready, out_valid, done, err}); end
    n_checks++; if ({wif.addr_i, wif.dat_i, xfer_cnt} !== 64'h0) begin
      n_fail++; $display("FAIL reset_values addr=%h dat=%h xfer=%h want 0", wif.addr_i, wif.dat_i, xfer_cnt); end
  endtask

  task automatic test_read();
    logic seen, e; logic [15:0] x; int cyc, d0;
    logic [15:0] exp_rd [4];
    exp_rd = '{16'hA4A5, 16'hA4A4, 16'hA4A7, 16'hA4A6};
    txn_q.delete(); out_q.delete(); out_ready = 1'b1; resp_on = 1'b1; d0 = done_cnt;
    issue_cmd(1'b0, 32'h100, 16'd4);
    // a command offered mid-transfer must be ignored
    repeat (3) @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h5000; cmd_len = 16'd7;
    @(posedge clk); #1 cmd_valid = 1'b0;
    wait_done(300, seen, cyc, e, x);
    repeat (3) @(negedge clk);
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL read_done_seen got=%b want=1", seen); end
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL read_err got=%b want=0", e); end
    n_checks++; if (x !== 16'd4) begin n_fail++; $display("FAIL read_xfer_cnt got=%0d want=4", x); end
    n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL read_done_count got=%0d want=1", done_cnt - d0); end
    n_checks++; if (txn_q.size() !== 4 || out_q.size() !== 4) begin
      n_fail++; $display("FAIL read_counts txns=%0d words=%0d want 4/4", txn_q.size(), out_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++; if (txn_q[i].addr !== 32'h100 + 32'(i) || txn_q[i].we !== 1'b0) begin
          n_fail++; $display("FAIL read_addr[%0d] got=%h we=%b want=%h we=0", i, txn_q[i].addr, txn_q[i].we, 32'h100 + 32'(i)); end
        n_checks++; if (out_q[i] !== exp_rd[i]) begin
          n_fail++; $display("FAIL read_data[%0d] got=%h want=%h", i, out_q[i], exp_rd[i]); end
      end
    end
    n_checks++; if (stb_viol !== 0 || sel_viol !== 0) begin
      n_fail++; $display("FAIL read_bus_rules stb_viol=%0d sel_viol=%0d want 0/0", stb_viol, sel_viol); end
  endtask

  task automatic test_write();
    logic seen, e; logic [15:0] x; int cyc;
    logic [15:0] wd [3];
    wd = '{16'h1111, 16'h2222, 16'h3333};
    txn_q.delete(); resp_on = 1'b1; prod_gap_max = 2;
    for (int i = 0; i < 3; i++) prod_q.push_back(wd[i]);
    issue_cmd(1'b1, 32'h20, 16'd3);
    wait_done(400, seen, cyc, e, x);
    repeat (2) @(negedge clk);
    n_checks++; if (seen !== 1'b1 || e !== 1'b0 || x !== 16'd3) begin
      n_fail++; $display("FAIL write_done seen=%b err=%b xfer=%0d want 1/0/3", seen, e, x); end
    n_checks++; if (txn_q.size() !== 3) begin n_fail++; $display("FAIL write_txn_count got=%0d want=3", txn_q.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++; if (txn_q[i] !== {1'b1, 32'h20 + 32'(i), wd[i]}) begin
          n_fail++; $display("FAIL write_txn[%0d] got we=%b addr=%h dat=%h want we=1 addr=%h dat=%h",
                             i, txn_q[i].we, txn_q[i].addr, txn_q[i].dat, 32'h20 + 32'(i), wd[i]); end
      end
    end
    n_checks++; if (prod_q.size() !== 0) begin n_fail++; $display("FAIL write_stream_left got=%0d want=0", prod_q.size()); end
    n_checks++; if (stb_viol !== 0) begin n_fail++; $display("FAIL write_stb_under_cyc got=%0d want=0", stb_viol); end
  endtask

  task automatic test_zero_len();
    logic seen, e; logic [15:0] x; int cyc, s0;
    txn_q.delete(); s0 = stb_cycles;
    issue_cmd(1'($urandom_range(0, 1)), $urandom, 16'd0);
    wait_done(10, seen, cyc, e, x);
    repeat (2) @(negedge clk);
    n_checks++; if (seen !== 1'b1 || cyc < 1 || cyc > 2) begin
      n_fail++; $display("FAIL zero_len_latency seen=%b cycles=%0d want done within 2", seen, cyc); end
    n_checks++; if (stb_cycles - s0 !== 0 || txn_q.size() !== 0) begin
      n_fail++; $display("FAIL zero_len_bus stb_cycles=%0d txns=%0d want 0/0", stb_cycles - s0, txn_q.size()); end
    n_checks++; if (x !== 16'd0 || e !== 1'b0) begin
      n_fail++; $display("FAIL zero_len_status xfer=%0d err=%b want 0/0", x, e); end
  endtask

  task automatic test_timeout();
    logic seen, e; logic [15:0] x; int cyc, s0;
    resp_on = 1'b0; out_ready = 1'b1; s0 = stb_cycles;
    issue_cmd(1'b0, $urandom, 16'd3);
    wait_done(100, seen, cyc, e, x);
    repeat (2) @(negedge clk);
    n_checks++; if (seen !== 1'b1 || e !== 1'b1 || x !== 16'd0) begin
      n_fail++; $display("FAIL timeout_status seen=%b err=%b xfer=%0d want 1/1/0", seen, e, x); end
    n_checks++; if (stb_cycles - s0 !== TMO) begin
      n_fail++; $display("FAIL timeout_stb_cycles got=%0d want=%0d", stb_cycles - s0, TMO); end
    n_checks++; if (err !== 1'b1 || wif.stb_i !== 1'b0) begin
      n_fail++; $display("FAIL timeout_err_held err=%b stb=%b want 1/0", err, wif.stb_i); end
    resp_on = 1'b1; out_q.delete();
    issue_cmd(1'b0, 32'h300, 16'd1);
    @(negedge clk);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL timeout_err_cleared got=%b want=0", err); end
    wait_done(100, seen, cyc, e, x);
    repeat (2) @(negedge clk);
    n_checks++; if (seen !== 1'b1 || e !== 1'b0 || x !== 16'd1) begin
      n_fail++; $display("FAIL timeout_recover seen=%b err=%b xfer=%0d want 1/0/1", seen, e, x); end
    n_checks++; if (out_q.size() !== 1 || out_q[0] !== 16'hA6A5) begin
      n_fail++; $display("FAIL timeout_recover_data words=%0d first=%h want 1/a6a5", out_q.size(), out_q[0]); end
  endtask

  task automatic test_backpressure();
    logic seen, e; logic [15:0] x; int cyc; logic [31:0] a; logic [15:0] exp0, exp1;
    a = $urandom; exp0 = a[15:0] ^ 16'hA5A5; exp1 = 16'(a + 32'd1) ^ 16'hA5A5;
    resp_on = 1'b1; out_ready = 1'b0; out_q.delete(); txn_q.delete();
    issue_cmd(1'b0, a, 16'd2);
    seen = 1'b0; cyc = 0;
    while (!seen && cyc < 100) begin @(negedge clk); cyc++; seen = (out_valid === 1'b1); end
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid_seen got=%b want=1", seen); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1 || out_data !== exp0) begin
        n_fail++; $display("FAIL bp_hold[%0d] valid=%b data=%h want 1/%h", k, out_valid, out_data, exp0); end
      n_checks++; if (txn_q.size() !== 1 || wif.stb_i !== 1'b0) begin
        n_fail++; $display("FAIL bp_no_strobe[%0d] txns=%0d stb=%b want 1/0", k, txn_q.size(), wif.stb_i); end
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_done(100, seen, cyc, e, x);
    repeat (2) @(negedge clk);
    n_checks++; if (seen !== 1'b1 || x !== 16'd2 || e !== 1'b0) begin
      n_fail++; $display("FAIL bp_done seen=%b xfer=%0d err=%b want 1/2/0", seen, x, e); end
    n_checks++; if (out_q.size() !== 2 || out_q[0] !== exp0 || out_q[1] !== exp1) begin
      n_fail++; $display("FAIL bp_data words=%0d got=%h,%h want %h,%h", out_q.size(), out_q[0], out_q[1], exp0, exp1); end
  endtask

  task automatic test_reset_mid();
    logic seen, e; logic [15:0] x; int cyc, d0;
    resp_on = 1'b1; out_ready = 1'b1;
    issue_cmd(1'b0, 32'h500, 16'd3);
    seen = 1'b0; cyc = 0;
    while (!seen && cyc < 50) begin @(negedge clk); cyc++; seen = (wif.cyc_o === 1'b1 && wif.stb_i === 1'b0); end
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rstmid_reach_wait got=%b want=1", seen); end
    d0 = done_cnt;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (wif.stb_i !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_after stb=%b ready=%b done=%b want 0/1/0", wif.stb_i, cmd_ready, done); end
    repeat (20) @(negedge clk);
    n_checks++; if (done_cnt !== d0) begin n_fail++; $display("FAIL rstmid_no_done got=%0d want=%0d", done_cnt, d0); end
    out_q.delete(); txn_q.delete();
    issue_cmd(1'b0, 32'h600, 16'd1);
    wait_done(100, seen, cyc, e, x);
    repeat (2) @(negedge clk);
    n_checks++; if (seen !== 1'b1 || x !== 16'd1 || e !== 1'b0 || out_q.size() !== 1 || out_q[0] !== 16'hA3A5) begin
      n_fail++; $display("FAIL rstmid_recover seen=%b xfer=%0d err=%b words=%0d data=%h want 1/1/0/1/a3a5",
                         seen, x, e, out_q.size(), out_q[0]); end
  endtask

  task automatic test_random();
    logic seen, e, wr; logic [15:0] x, n; int cyc; logic [31:0] a;
    logic [15:0] exp_d[$];
    resp_on = 1'b1; out_ready = 1'b1;
    for (int it = 0; it < 8; it++) begin
      wr = 1'($urandom_range(0, 1));
      n  = (it == 3) ? 16'd4 : 16'($urandom_range(0, 5));
      a  = (it == 3) ? 32'hFFFF_FFFE : $urandom;
      exp_d.delete();
      for (int i = 0; i < int'(n); i++) exp_d.push_back(16'($urandom));
      txn_q.delete(); out_q.delete();
      if (wr) begin
        prod_gap_max = $urandom_range(0, 3);
        for (int i = 0; i < int'(n); i++) prod_q.push_back(exp_d[i]);
      end
      issue_cmd(wr, a, n);
      wait_done(600, seen, cyc, e, x);
      repeat (2) @(negedge clk);
      n_checks++; if (seen !== 1'b1 || e !== 1'b0 || x !== n) begin
        n_fail++; $display("FAIL rand%0d_done seen=%b err=%b xfer=%0d want 1/0/%0d", it, seen, e, x, n); end
      n_checks++; if (txn_q.size() !== int'(n) || (!wr && out_q.size() !== int'(n))) begin
        n_fail++; $display("FAIL rand%0d_counts txns=%0d words=%0d want %0d", it, txn_q.size(), out_q.size(), n); end
      else begin
        for (int i = 0; i < int'(n); i++) begin
          n_checks++; if (txn_q[i].we !== wr || txn_q[i].addr !== a + 32'(i) || (wr && txn_q[i].dat !== exp_d[i])) begin
            n_fail++; $display("FAIL rand%0d_txn[%0d] got we=%b addr=%h dat=%h want we=%b addr=%h", it, i,
                               txn_q[i].we, txn_q[i].addr, txn_q[i].dat, wr, a + 32'(i)); end
          if (!wr) begin
            n_checks++; if (out_q[i] !== (16'(a + 32'(i)) ^ 16'hA5A5)) begin
              n_fail++; $display("FAIL rand%0d_rdata[%0d] got=%h want=%h", it, i, out_q[i], 16'(a + 32'(i)) ^ 16'hA5A5); end
          end
        end
      end
    end
    n_checks++; if (stb_viol !== 0 || sel_viol !== 0) begin
      n_fail++; $display("FAIL rand_bus_rules stb_viol=%0d sel_viol=%0d want 0/0", stb_viol, sel_viol); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_len = 16'h0;
    out_ready = 1'b1; resp_on = 1'b1;
    test_reset();
    test_read();
    test_write();
    test_zero_len();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
